sram_bank_ctrl: RTL

- Parametrised SRAM bank: DEPTH words of DATA_WIDTH bits, behavioural storage array.
- Request/response valid-ready front end; per-op explicit wordline (access) cycle; byte-enable writes; read capture register.
- Hardware init sweep after reset or on request.
- Sits between core load/store unit and on-chip data memory; replaces single-word, WL-strobed storage rows.

---
 rtl/sram_bank_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/sram_bank_ctrl.sv
// SRAM bank controller: valid/ready front end, one wordline cycle per op,
// byte-merge writes, read capture register and a hardware init sweep.
module sram_bank_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH = 64,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int BE_W = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  init_req,
    output logic                  init_done,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [BE_W-1:0]       req_be,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err
);

    typedef enum logic [1:0] {
        S_INIT,
        S_IDLE,
        S_ACCESS,
        S_RESP
    } state_t;

    typedef struct packed {
        logic                  we;
        logic [ADDR_W-1:0]     addr;
        logic [DATA_WIDTH-1:0] wdata;
        logic [BE_W-1:0]       be;
    } op_t;

    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    state_t state, state_nx;
    op_t    op;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_W-1:0]     cnt;
    logic [DATA_WIDTH-1:0] cap;
    logic                  err;
    logic                  done;

    logic                  req_hs;
    logic                  in_range;
    logic                  sweep_end;
    logic [DATA_WIDTH-1:0] old_word;
    logic [DATA_WIDTH-1:0] merged;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    assign req_ready = (state == S_IDLE);
    assign rsp_valid = (state == S_RESP);
    assign rsp_rdata = cap;
    assign rsp_err   = err;
    assign init_done = done;

    assign req_hs    = req_valid && req_ready;
    assign in_range  = {1'b0, op.addr} < DEPTH_C;
    assign sweep_end = (cnt == LAST);
    assign old_word  = in_range ? mem[op.addr] : '0;

    always_comb begin
        merged = old_word;
        for (int k = 0; k < BE_W; k++) begin
            if (op.be[k]) merged[8*k +: 8] = op.wdata[8*k +: 8];
        end
    end

    // The sweep and the wordline cycle are the only array writers.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = op.addr;
        mem_wdata = merged;
        if (rst_n) begin
            if (state == S_INIT) begin
                mem_we    = 1'b1;
                mem_addr  = cnt;
                mem_wdata = INIT_VALUE;
            end else if (state == S_ACCESS) begin
                mem_we = op.we && in_range;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_INIT: begin
                if (sweep_end) state_nx = S_IDLE;
            end
            S_IDLE: begin
                if (req_hs) state_nx = S_ACCESS;
                else if (init_req) state_nx = S_INIT;
            end
            S_ACCESS: state_nx = S_RESP;
            S_RESP: begin
                if (rsp_ready) state_nx = S_IDLE;
            end
            default: state_nx = S_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_INIT;
        else state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            done <= 1'b0;
            op   <= '0;
            cap  <= '0;
            err  <= 1'b0;
        end else begin
            unique case (state)
                S_INIT: begin
                    cnt  <= sweep_end ? '0 : cnt + 1'b1;
                    done <= sweep_end;
                end
                S_IDLE: begin
                    if (req_hs) begin
                        op <= '{we: req_we, addr: req_addr,
                                wdata: req_wdata, be: req_be};
                    end else if (init_req) begin
                        done <= 1'b0;
                        cnt  <= '0;
                    end
                end
                S_ACCESS: begin
                    cap <= !in_range ? '0 : (op.we ? merged : old_word);
                    err <= !in_range;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        cap <= '0;
                        err <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
